// File: rtl/mux_n_scan_if.sv
// Channel bus for mux_n_scan: packed channel data and selection controls in,
// registered selected data, current selection and change pulse out.
interface mux_n_scan_if #(
  parameter int N_CH = 4,
  parameter int W    = 8
);
  localparam int SW = $clog2(N_CH);

  logic [N_CH*W-1:0] data_in;
  logic [SW-1:0]     sel_in;
  logic [1:0]        mode;
  logic              step;
  logic [W-1:0]      y;
  logic [SW-1:0]     sel_cur;
  logic              sel_changed;

  modport master (
    output data_in, sel_in, mode, step,
    input  y, sel_cur, sel_changed
  );

  modport slave (
    input  data_in, sel_in, mode, step,
    output y, sel_cur, sel_changed
  );
endinterface

// File: rtl/mux_n_scan.sv
// N-channel registered multiplexer whose selection is set directly, stepped by a key,
// auto-scanned on a fixed period, or held. Every output comes straight from a register.
module mux_n_scan #(
  parameter int N_CH     = 4,
  parameter int W        = 8,
  parameter int SCAN_DIV = 1000
) (
  input logic         clock,
  input logic         reset,
  mux_n_scan_if.slave bus
);
  localparam int SW = $clog2(N_CH);
  localparam int CW = $clog2(SCAN_DIV);

  localparam logic [SW-1:0] LAST_CH  = SW'(N_CH - 1);
  localparam logic [SW:0]   N_CH_EXT = (SW + 1)'(N_CH);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_STEP   = 2'b01,
    MODE_AUTO   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  mode_e         mode;
  logic [SW-1:0] sel_q, sel_d, sel_inc;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          step_prev_q;
  logic          step_edge;
  logic [W-1:0]  y_q;
  logic          changed_q;

  assign mode      = mode_e'(bus.mode);
  assign step_edge = bus.step & ~step_prev_q;
  // Explicit wrap so non-power-of-2 channel counts never reach an unused code.
  assign sel_inc   = (sel_q == LAST_CH) ? '0 : sel_q + 1'b1;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    sel_d = sel_q;
    cnt_d = '0;
    unique case (mode)
      MODE_DIRECT: sel_d = ({1'b0, bus.sel_in} >= N_CH_EXT) ? LAST_CH : bus.sel_in;
      MODE_STEP:   if (step_edge) sel_d = sel_inc;
      MODE_AUTO: begin
        if (cnt_q == CNT_LAST) sel_d = sel_inc;
        else                   cnt_d = cnt_q + 1'b1;
      end
      MODE_HOLD:   sel_d = sel_q;
    endcase
  end

  // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      sel_q       <= '0;
      y_q         <= '0;
      changed_q   <= 1'b0;
      cnt_q       <= '0;
      // A key held through reset must not register as a fresh press on release.
      step_prev_q <= 1'b1;
    end else begin
      sel_q       <= sel_d;
      y_q         <= bus.data_in[int'(sel_q) * W +: W];
      changed_q   <= (sel_d != sel_q);
      cnt_q       <= cnt_d;
      step_prev_q <= bus.step;
    end
  end

  assign bus.y           = y_q;
  assign bus.sel_cur     = sel_q;
  assign bus.sel_changed = changed_q;
endmodule

// File: tb/tb_mux_n_scan.sv
// Scoreboard bench for mux_n_scan: two instances (4 ch x 8 bit, 3 ch x 32 bit) share
// control stimulus; a reference model queues expectations, a monitor compares each cycle.
module tb_mux_n_scan;
  localparam int NA = 4, WA = 8,  DA = 4;
  localparam int NB = 3, WB = 32, DB = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mux_n_scan_if #(.N_CH(NA), .W(WA)) bus_a ();
  mux_n_scan_if #(.N_CH(NB), .W(WB)) bus_b ();

  mux_n_scan #(.N_CH(NA), .W(WA), .SCAN_DIV(DA)) dut_a (.clock(clock), .reset(reset), .bus(bus_a));
  mux_n_scan #(.N_CH(NB), .W(WB), .SCAN_DIV(DB)) dut_b (.clock(clock), .reset(reset), .bus(bus_b));

  typedef struct {
    logic [31:0] sel;
    logic [31:0] y;
    logic [31:0] chg;
  } exp_t;

  exp_t        q_exp [2][$];
  logic [31:0] dat   [2][16];

  // Reference model state, one slot per instance.
  int          m_sel  [2];
  int          m_cnt  [2];
  bit          m_prev [2];
  logic [31:0] m_y    [2];
  bit          m_chg  [2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string name, logic [31:0] actual, logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
    end
  endtask

  // Behavioural model of one clock edge, written from the selection rules directly.
  task automatic model_step(int k, int n, int div, bit r, int m, int s, bit st);
    int   nsel;
    int   ncnt;
    exp_t e;
    if (r) begin
      m_sel[k] = 0; m_cnt[k] = 0; m_prev[k] = 1'b1; m_y[k] = '0; m_chg[k] = 1'b0;
    end else begin
      nsel = m_sel[k];
      ncnt = 0;
      case (m)
        0: nsel = (s > n - 1) ? n - 1 : s;
        1: if (st && !m_prev[k]) nsel = (m_sel[k] + 1) % n;
        2: begin
          ncnt = (m_cnt[k] + 1) % div;
          if (ncnt == 0) nsel = (m_sel[k] + 1) % n;
        end
        default: ;
      endcase
      m_y[k]    = dat[k][m_sel[k]];
      m_chg[k]  = (nsel != m_sel[k]);
      m_sel[k]  = nsel;
      m_cnt[k]  = ncnt;
      m_prev[k] = st;
    end
    e.sel = 32'(m_sel[k]);
    e.y   = m_y[k];
    e.chg = {31'b0, m_chg[k]};
    q_exp[k].push_back(e);
  endtask

  // Applies one cycle of stimulus at a falling edge and returns at the next falling edge.
  task automatic cycle(bit r, int m, int s, bit st);
    reset        = r;
    bus_a.mode   = 2'(m);
    bus_b.mode   = 2'(m);
    bus_a.sel_in = 2'(s);
    bus_b.sel_in = 2'(s);
    bus_a.step   = st;
    bus_b.step   = st;
    for (int i = 0; i < NA; i++) bus_a.data_in[i*WA +: WA] = dat[0][i][WA-1:0];
    for (int i = 0; i < NB; i++) bus_b.data_in[i*WB +: WB] = dat[1][i];
    model_step(0, NA, DA, r, m, s, st);
    model_step(1, NB, DB, r, m, s, st);
    @(negedge clock);
  endtask

  task automatic randomize_data();
    for (int i = 0; i < 16; i++) begin
      dat[0][i] = 32'($urandom_range(0, 255));
      dat[1][i] = $urandom;
    end
  endtask

  // Monitor: compares every registered output just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #2;
      if (q_exp[0].size() > 0) begin
        e = q_exp[0].pop_front();
        check("a_sel_cur", 32'(bus_a.sel_cur), e.sel);
        check("a_y", 32'(bus_a.y), e.y);
        check("a_sel_changed", 32'(bus_a.sel_changed), e.chg);
      end
      if (q_exp[1].size() > 0) begin
        e = q_exp[1].pop_front();
        check("b_sel_cur", 32'(bus_b.sel_cur), e.sel);
        check("b_y", bus_b.y, e.y);
        check("b_sel_changed", 32'(bus_b.sel_changed), e.chg);
      end
    end
  end

  initial begin
    int mode_r;
    bit step_r;
    bus_a.data_in = '0; bus_b.data_in = '0;
    bus_a.sel_in  = '0; bus_b.sel_in  = '0;
    bus_a.mode    = '0; bus_b.mode    = '0;
    bus_a.step    = 1'b0; bus_b.step  = 1'b0;
    randomize_data();
    @(negedge clock);

    // Reset state.
    repeat (3) cycle(1, 0, 0, 0);
    check("rst_sel_cur", 32'(bus_a.sel_cur), 0);
    check("rst_y", 32'(bus_a.y), 0);
    check("rst_sel_changed", 32'(bus_a.sel_changed), 0);

    // Direct mode: channel 2 selected after one edge, its data one edge later.
    dat[0][0] = 32'h11; dat[0][1] = 32'h22; dat[0][2] = 32'h33; dat[0][3] = 32'h44;
    cycle(0, 0, 2, 0);
    check("direct_sel", 32'(bus_a.sel_cur), 2);
    check("direct_pulse", 32'(bus_a.sel_changed), 1);
    cycle(0, 0, 2, 0);
    check("direct_y", 32'(bus_a.y), 32'h33);
    check("direct_no_repulse", 32'(bus_a.sel_changed), 0);

    // Step mode: isolated pulses, then one long press.
    cycle(0, 0, 0, 0);
    for (int p = 0; p < 5; p++) begin
      cycle(0, 1, 0, 1);
      cycle(0, 1, 0, 0);
      cycle(0, 1, 0, 0);
      check("step_seq_a", 32'(bus_a.sel_cur), 32'((p + 1) % NA));
      check("step_seq_b", 32'(bus_b.sel_cur), 32'((p + 1) % NB));
    end
    repeat (10) cycle(0, 1, 0, 1);
    cycle(0, 1, 0, 0);
    check("step_held_once", 32'(bus_a.sel_cur), 2);

    // Auto-scan, interrupted by hold, then resumed with a fresh full period.
    cycle(0, 0, 0, 0);
    repeat (4) cycle(0, 2, 0, 0);
    check("auto_first", 32'(bus_a.sel_cur), 1);
    repeat (4) cycle(0, 2, 0, 0);
    check("auto_second", 32'(bus_a.sel_cur), 2);
    cycle(0, 2, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 3, $urandom_range(0, 3), (i % 2) == 1);
    check("hold_kept", 32'(bus_a.sel_cur), 2);
    repeat (3) cycle(0, 2, 0, 0);
    check("auto_reentry_wait", 32'(bus_a.sel_cur), 2);
    cycle(0, 2, 0, 0);
    check("auto_reentry_adv", 32'(bus_a.sel_cur), 3);

    // Out-of-range direct request clamps; advancing from the last channel wraps.
    cycle(0, 0, 3, 0);
    check("clamp_b", 32'(bus_b.sel_cur), 2);
    cycle(0, 1, 3, 1);
    check("wrap_b", 32'(bus_b.sel_cur), 0);
    check("wrap_a", 32'(bus_a.sel_cur), 0);
    cycle(0, 1, 3, 0);

    // Reset mid-scan with the key held; release must not count as a press.
    repeat (6) cycle(0, 2, 0, 1);
    cycle(1, 2, 0, 1);
    check("midrst_sel", 32'(bus_a.sel_cur), 0);
    check("midrst_y", 32'(bus_a.y), 0);
    check("midrst_chg", 32'(bus_a.sel_changed), 0);
    repeat (3) cycle(0, 1, 0, 1);
    check("held_key_no_edge", 32'(bus_a.sel_cur), 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 1);
    check("key_repress", 32'(bus_a.sel_cur), 1);

    // Randomised traffic across all modes with changing data and occasional reset.
    mode_r = 0;
    step_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      randomize_data();
      if ($urandom_range(0, 7) == 0) mode_r = $urandom_range(0, 3);
      if ($urandom_range(0, 2) == 0) step_r = ~step_r;
      cycle($urandom_range(0, 99) == 0, mode_r, $urandom_range(0, 3), step_r);
    end

    cycle(0, 3, 0, 0);
    @(posedge clock);
    #3;
    check("scoreboard_drained", 32'(q_exp[0].size() + q_exp[1].size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_n_scan.md
MUX_N_SCAN -- requirements
Module: mux_n_scan

Parameters
REQ-001 N_CH, default 4, number of data channels; legal range 2..16.
REQ-002 W, default 8, data width per channel in bits; legal range 1..32.
REQ-003 SCAN_DIV, default 1000, clock cycles per auto-scan step; legal range 2..2^24.
REQ-004 SW, fixed at $clog2(N_CH), selector width; not user-overridable.

Interface
REQ-005 clock  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 data_in  input  N_CH*W  packed channels; channel i at bits [i*W +: W].
REQ-008 sel_in  input  SW  requested channel for direct mode.
REQ-009 mode  input  2  00 direct, 01 step, 10 auto-scan, 11 hold.
REQ-010 step  input  1  raw level from a key; block detects rising edges internally.
REQ-011 y  output  W  registered selected channel data.
REQ-012 sel_cur  output  SW  currently selected channel, registered.
REQ-013 sel_changed  output  1  one-cycle pulse when sel_cur changes value.

Function
REQ-014 Direct mode (00): sel_cur SHALL load sel_in every cycle; sel_in >= N_CH SHALL clamp to N_CH-1.
REQ-015 Step mode (01): sel_cur SHALL advance by 1 on each cycle where step=1 and previous-cycle step=0.
REQ-016 Auto mode (10): a scan counter SHALL count 0..SCAN_DIV-1; sel_cur SHALL advance by 1 in the cycle the counter wraps to 0.
REQ-017 Hold mode (11): sel_cur SHALL keep its value; step edges and sel_in SHALL be ignored.
REQ-018 Advance wrap: sel_cur = N_CH-1 SHALL advance to 0, including non-power-of-2 N_CH.
REQ-019 The scan counter SHALL clear to 0 in every cycle where mode != 10, so auto mode always begins with a full SCAN_DIV period.
REQ-020 The step edge detector SHALL sample step every cycle regardless of mode; an edge in a cycle with mode != 01 SHALL be discarded, not queued.
REQ-021 Mode change: the new mode value SHALL govern the update at the same clock edge; no extra cycle of old-mode behaviour.
REQ-022 y SHALL equal data_in[sel_cur] as registered one cycle earlier: sel_cur updated at edge k gives matching y at edge k+1 (latency 1).
REQ-023 With sel_cur stable, y SHALL track data_in with exactly 1 cycle latency.
REQ-024 sel_changed SHALL be 1 for exactly the cycle after an edge in which sel_cur took a different value; a direct-mode reload of the same value SHALL NOT pulse.
REQ-025 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-026 While reset=1 at a clock edge: sel_cur=0, y=0, sel_changed=0, scan counter=0.
REQ-027 The previous-step register SHALL reset to 1, so a step key held through reset generates no edge on release of reset.
REQ-028 Reset SHALL take priority over every mode and input, including mid-scan and mid-step.
REQ-029 In the first cycle after reset deasserts, normal operation SHALL resume from sel_cur=0.

Verification (N_CH=4, W=8, SCAN_DIV=4 unless stated)
REQ-030 Direct mode, data_in={8'h44,8'h33,8'h22,8'h11}, sel_in=2 -> sel_cur=2 after 1 edge, y=8'h33 after 2 edges, sel_changed pulses once.
REQ-031 Step mode, 5 isolated step pulses from sel_cur=0 -> sel_cur sequence 1,2,3,0,1; step held high 10 cycles -> exactly one advance.
REQ-032 Auto mode entered at cycle t from sel_cur=0 -> sel_cur=1 at t+4, 2 at t+8; hold (11) at t+9 for 20 cycles then back to 10 -> next advance exactly 4 cycles after re-entry.
REQ-033 N_CH=3: direct sel_in=3 -> sel_cur=2; step from 2 -> 0; no sel_cur value >= 3 ever observed.
REQ-034 Reset asserted mid auto-scan with step held high -> all outputs 0 at the next edge; after release with step still high, no advance in step mode until step falls and rises again.
REQ-035 Randomised data_in with fixed sel_cur, all modes -> y equals the selected channel delayed 1 cycle on every cycle; W=1 and W=32 builds pass the same check.
